// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART hex monitor.
//   MonState    - monitor FSM states
//   ASCII_*     - byte codes used for line parsing and the reply strings
//   reply_byte  - selects one byte of the "Ok\r\n" / "Er\r\n" reply
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ECHO_WAIT = 2'd1,
        RESP_SEND = 2'd2,
        RESP_WAIT = 2'd3
    } MonState;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_O  = 8'h4F;
    localparam logic [7:0] ASCII_K  = 8'h6B;
    localparam logic [7:0] ASCII_E  = 8'h45;
    localparam logic [7:0] ASCII_R  = 8'h72;

    // Reply string is indexed rather than stored: idx 0..3 walks "Ok\r\n" or "Er\r\n".
    function automatic logic [7:0] reply_byte(input logic [1:0] idx, input logic ok);
        case (idx)
            2'd0:    reply_byte = ok ? ASCII_O : ASCII_E;
            2'd1:    reply_byte = ok ? ASCII_K : ASCII_R;
            2'd2:    reply_byte = ASCII_CR;
            2'd3:    reply_byte = ASCII_LF;
            default: reply_byte = ASCII_LF;
        endcase
    endfunction

endpackage

// File: rtl/uart_hex_monitor_if.sv
// uart_hex_monitor_if: byte-level handshake between the monitor and the UART.
//   rx_complete/rx_byte - received byte strobe and data (UART -> monitor)
//   tx_start/tx_byte    - transmit request and data    (monitor -> UART)
//   tx_done             - transmitter finished a byte  (UART -> monitor)
// master = monitor side, slave = UART side.
interface uart_hex_monitor_if;
    logic       rx_complete;
    logic [7:0] rx_byte;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_done;

    modport master (
        input  rx_complete, rx_byte, tx_done,
        output tx_start, tx_byte
    );

    modport slave (
        output rx_complete, rx_byte, tx_done,
        input  tx_start, tx_byte
    );
endinterface

// File: rtl/uart_hex_monitor_hex_ascii_decode.sv
// hex_ascii_decode: combinational ASCII hex character decoder.
//   ascii_in - received byte
//   is_hex   - 1 for '0'-'9', 'a'-'f', 'A'-'F'
//   nibble   - value of the hex digit (0 when not hex)
module hex_ascii_decode (
    input  logic [7:0] ascii_in,
    output logic       is_hex,
    output logic [3:0] nibble
);

    // Classify the byte; letters map via low nibble + 9 ('A'/'a' low nibble is 1).
    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        if ((ascii_in >= 8'h30) && (ascii_in <= 8'h39)) begin
            is_hex = 1'b1;
            nibble = ascii_in[3:0];
        end else if (((ascii_in >= 8'h41) && (ascii_in <= 8'h46)) ||
                     ((ascii_in >= 8'h61) && (ascii_in <= 8'h66))) begin
            is_hex = 1'b1;
            nibble = ascii_in[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
            nibble = 4'h0;
        end
    end

endmodule

// File: rtl/uart_hex_monitor.sv
// uart_hex_monitor: accumulates ASCII hex digits from the UART receiver,
// optionally echoes them, and commits the value on CR with an "Ok\r\n" or
// "Er\r\n" reply through the UART transmitter.
//   clk, reset   - clock and synchronous active-high reset
//   bus          - rx/tx byte handshake (master modport)
//   value_out    - last committed value (4*DIGITS bits)
//   value_valid  - one-cycle pulse when value_out updates
//   digit_count  - digits on the current line, saturating at DIGITS+1
//   overrun      - sticky: an rx byte was dropped because the monitor was busy
module uart_hex_monitor
    import uart_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int ECHO   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_hex_monitor_if.master     bus,
    output logic [4*DIGITS-1:0]    value_out,
    output logic                   value_valid,
    output logic [3:0]             digit_count,
    output logic                   overrun
);

    localparam int         W       = 4 * DIGITS;
    localparam logic [3:0] CNT_LIM = 4'(DIGITS);
    localparam logic [3:0] CNT_MAX = 4'(DIGITS + 32'sd1);
    localparam logic       ECHO_EN = (ECHO != 32'sd0);

    MonState        state_r, state_s;
    logic [W-1:0]   acc_r, acc_s;
    logic [W-1:0]   value_r, value_s;
    logic [3:0]     cnt_r, cnt_s;
    logic [1:0]     idx_r, idx_s;
    logic [7:0]     tx_byte_r, tx_byte_s;
    logic           err_r, err_s;
    logic           ok_r, ok_s;
    logic           echo_cr_r, echo_cr_s;
    logic           tx_start_r, tx_start_s;
    logic           valid_r, valid_s;
    logic           overrun_r, overrun_s;
    logic           is_hex_s;
    logic [3:0]     nibble_s;
    logic           is_cr_s;
    logic           line_ok_s;

    hex_ascii_decode u_decode (
        .ascii_in (bus.rx_byte),
        .is_hex   (is_hex_s),
        .nibble   (nibble_s)
    );

    assign is_cr_s   = (bus.rx_byte == ASCII_CR);
    // A line commits only with 1..DIGITS digits and no invalid character seen.
    assign line_ok_s = (cnt_r != 4'd0) && (cnt_r <= CNT_LIM) && !err_r;

    // Next-state and next-register values for the line parser and reply sequencer.
    always_comb begin
        state_s    = state_r;
        acc_s      = acc_r;
        value_s    = value_r;
        cnt_s      = cnt_r;
        idx_s      = idx_r;
        tx_byte_s  = tx_byte_r;
        err_s      = err_r;
        ok_s       = ok_r;
        echo_cr_s  = echo_cr_r;
        tx_start_s = 1'b0;
        valid_s    = 1'b0;
        overrun_s  = overrun_r;

        // Any byte arriving while busy is dropped, even alongside tx_done.
        if (bus.rx_complete && (state_r != IDLE)) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = overrun_r;
        end

        case (state_r)
            IDLE: begin
                if (bus.rx_complete && (bus.rx_byte != ASCII_LF)) begin
                    echo_cr_s = is_cr_s;
                    if (is_cr_s) begin
                        ok_s  = line_ok_s;
                        idx_s = 2'd0;
                        acc_s = '0;
                        cnt_s = 4'd0;
                        err_s = 1'b0;
                        if (line_ok_s) begin
                            value_s = acc_r;
                            valid_s = 1'b1;
                        end else begin
                            value_s = value_r;
                        end
                    end else if (is_hex_s) begin
                        acc_s = (acc_r << 4) | W'(nibble_s);
                        if (cnt_r < CNT_MAX) begin
                            cnt_s = cnt_r + 4'd1;
                        end else begin
                            cnt_s = cnt_r;
                        end
                    end else begin
                        err_s = 1'b1;
                    end

                    // Echo takes priority; without echo a CR starts the reply at once.
                    if (ECHO_EN) begin
                        state_s    = ECHO_WAIT;
                        tx_start_s = 1'b1;
                        tx_byte_s  = bus.rx_byte;
                    end else if (is_cr_s) begin
                        state_s    = RESP_SEND;
                        tx_start_s = 1'b1;
                        tx_byte_s  = reply_byte(2'd0, line_ok_s);
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            ECHO_WAIT: begin
                if (bus.tx_done) begin
                    if (echo_cr_r) begin
                        state_s    = RESP_SEND;
                        tx_start_s = 1'b1;
                        tx_byte_s  = reply_byte(idx_r, ok_r);
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = ECHO_WAIT;
                end
            end

            // tx_start is already high in this cycle; just wait for completion.
            RESP_SEND: begin
                state_s = RESP_WAIT;
            end

            RESP_WAIT: begin
                if (bus.tx_done) begin
                    if (idx_r != 2'd3) begin
                        idx_s      = idx_r + 2'd1;
                        state_s    = RESP_SEND;
                        tx_start_s = 1'b1;
                        tx_byte_s  = reply_byte(idx_r + 2'd1, ok_r);
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = RESP_WAIT;
                end
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r      <= '0;
            value_r    <= '0;
            cnt_r      <= 4'd0;
            idx_r      <= 2'd0;
            tx_byte_r  <= 8'h00;
            err_r      <= 1'b0;
            ok_r       <= 1'b0;
            echo_cr_r  <= 1'b0;
            tx_start_r <= 1'b0;
            valid_r    <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            acc_r      <= acc_s;
            value_r    <= value_s;
            cnt_r      <= cnt_s;
            idx_r      <= idx_s;
            tx_byte_r  <= tx_byte_s;
            err_r      <= err_s;
            ok_r       <= ok_s;
            echo_cr_r  <= echo_cr_s;
            tx_start_r <= tx_start_s;
            valid_r    <= valid_s;
            overrun_r  <= overrun_s;
        end
    end

    assign bus.tx_start = tx_start_r;
    assign bus.tx_byte  = tx_byte_r;
    assign value_out    = value_r;
    assign value_valid  = valid_r;
    assign digit_count  = cnt_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_uart_hex_monitor.sv
// Directed testbench for uart_hex_monitor with three configurations:
//   u_a: DIGITS=2 ECHO=1, u_b: DIGITS=2 ECHO=0, u_c: DIGITS=8 ECHO=1.
module tb_uart_hex_monitor;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   txcnt_c = 0;

    always #5 clk = ~clk;

    uart_hex_monitor_if if_a ();
    uart_hex_monitor_if if_b ();
    uart_hex_monitor_if if_c ();

    logic       rxc [3];
    logic [7:0] rxb [3];
    logic       txd [3];

    assign if_a.rx_complete = rxc[0];
    assign if_a.rx_byte     = rxb[0];
    assign if_a.tx_done     = txd[0];
    assign if_b.rx_complete = rxc[1];
    assign if_b.rx_byte     = rxb[1];
    assign if_b.tx_done     = txd[1];
    assign if_c.rx_complete = rxc[2];
    assign if_c.rx_byte     = rxb[2];
    assign if_c.tx_done     = txd[2];

    logic [7:0]  val_a, val_b;
    logic [31:0] val_c;
    logic        vv_a, vv_b, vv_c;
    logic [3:0]  dc_a, dc_b, dc_c;
    logic        ov_a, ov_b, ov_c;

    uart_hex_monitor #(.DIGITS(2), .ECHO(1)) u_a (
        .clk(clk), .reset(reset), .bus(if_a.master), .value_out(val_a),
        .value_valid(vv_a), .digit_count(dc_a), .overrun(ov_a));
    uart_hex_monitor #(.DIGITS(2), .ECHO(0)) u_b (
        .clk(clk), .reset(reset), .bus(if_b.master), .value_out(val_b),
        .value_valid(vv_b), .digit_count(dc_b), .overrun(ov_b));
    uart_hex_monitor #(.DIGITS(8), .ECHO(1)) u_c (
        .clk(clk), .reset(reset), .bus(if_c.master), .value_out(val_c),
        .value_valid(vv_c), .digit_count(dc_c), .overrun(ov_c));

    // Count tx_start pulses of the wide instance.
    always @(negedge clk) begin
        if (reset) txcnt_c <= 0;
        else if (if_c.tx_start) txcnt_c <= txcnt_c + 1;
    end

    function automatic logic g_txs(int u);
        case (u)
            0: g_txs = if_a.tx_start;
            1: g_txs = if_b.tx_start;
            default: g_txs = if_c.tx_start;
        endcase
    endfunction

    function automatic logic [7:0] g_txb(int u);
        case (u)
            0: g_txb = if_a.tx_byte;
            1: g_txb = if_b.tx_byte;
            default: g_txb = if_c.tx_byte;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(int u, logic [7:0] b);
        rxc[u] = 1'b1;
        rxb[u] = b;
        tick();
        rxc[u] = 1'b0;
    endtask

    // Wait for tx_start, check byte and one-cycle pulse, then answer with tx_done.
    // mode 0: plain tx_done; mode 1: rx alone then rx coincident with tx_done; mode 2: no tx_done.
    task automatic serve_tx(int u, logic [7:0] exp, string name, int mode);
        int w = 0;
        while (!g_txs(u) && w < 20) begin
            tick();
            w++;
        end
        checks++;
        if (g_txs(u) !== 1'b1) begin
            errors++;
            $display("FAIL %s tx_start timeout got %b need 1", name, g_txs(u));
        end else begin
            checks++;
            if (g_txb(u) !== exp) begin
                errors++;
                $display("FAIL %s tx_byte got %h need %h", name, g_txb(u), exp);
            end
            tick();
            checks++;
            if (g_txs(u) !== 1'b0) begin
                errors++;
                $display("FAIL %s tx_start_width got %b need 0", name, g_txs(u));
            end
            if (mode == 1) begin
                rxc[u] = 1'b1;
                rxb[u] = 8'h39;
                tick();
                txd[u] = 1'b1;
                rxb[u] = 8'h35;
                tick();
                rxc[u] = 1'b0;
                txd[u] = 1'b0;
            end else if (mode == 0) begin
                tick();
                txd[u] = 1'b1;
                tick();
                txd[u] = 1'b0;
            end
        end
    endtask

    task automatic serve_reply(int u, logic ok, string name);
        serve_tx(u, ok ? 8'h4F : 8'h45, name, 0);
        serve_tx(u, ok ? 8'h6B : 8'h72, name, 0);
        serve_tx(u, 8'h0D, name, 0);
        serve_tx(u, 8'h0A, name, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rxc[i] = 1'b0; rxb[i] = 8'h00; txd[i] = 1'b0;
        end
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (g_txs(u) !== 1'b0 || g_txb(u) !== 8'h00) begin
                errors++;
                $display("FAIL reset_tx[%0d] got %b/%h need 0/00", u, g_txs(u), g_txb(u));
            end
        end
        checks++;
        if ({val_a, val_b, val_c} !== 48'h0 || {vv_a, vv_b, vv_c} !== 3'b000) begin
            errors++;
            $display("FAIL reset_value got %h %h %h v=%b need 0", val_a, val_b, val_c, {vv_a, vv_b, vv_c});
        end
        checks++;
        if ({dc_a, dc_b, dc_c} !== 12'h000 || {ov_a, ov_b, ov_c} !== 3'b000) begin
            errors++;
            $display("FAIL reset_count got %h ov=%b need 000/000", {dc_a, dc_b, dc_c}, {ov_a, ov_b, ov_c});
        end
    endtask

    task automatic test_echo_commit();
        send_rx(0, 8'h33);
        checks++;
        if (dc_a !== 4'd1) begin errors++; $display("FAIL echo_cnt1 got %0d need 1", dc_a); end
        serve_tx(0, 8'h33, "echo_3", 0);
        send_rx(0, 8'h46);
        checks++;
        if (dc_a !== 4'd2) begin errors++; $display("FAIL echo_cnt2 got %0d need 2", dc_a); end
        serve_tx(0, 8'h46, "echo_F", 0);
        send_rx(0, 8'h0D);
        checks++;
        if (vv_a !== 1'b1 || val_a !== 8'h3F || dc_a !== 4'd0) begin
            errors++;
            $display("FAIL commit_3F got v=%b val=%h cnt=%0d need 1/3f/0", vv_a, val_a, dc_a);
        end
        serve_tx(0, 8'h0D, "echo_cr", 0);
        checks++;
        if (vv_a !== 1'b0) begin errors++; $display("FAIL valid_pulse got %b need 0", vv_a); end
        serve_reply(0, 1'b1, "reply_ok_3F");
    endtask

    task automatic test_too_long();
        string s = "12A";
        for (int i = 0; i < 3; i++) begin
            send_rx(0, s[i]);
            serve_tx(0, s[i], "echo_12A", 0);
        end
        checks++;
        if (dc_a !== 4'd3) begin errors++; $display("FAIL sat_cnt got %0d need 3", dc_a); end
        send_rx(0, 8'h0D);
        checks++;
        if (vv_a !== 1'b0 || val_a !== 8'h3F || dc_a !== 4'd0) begin
            errors++;
            $display("FAIL too_long got v=%b val=%h cnt=%0d need 0/3f/0", vv_a, val_a, dc_a);
        end
        serve_tx(0, 8'h0D, "echo_cr2", 0);
        serve_reply(0, 1'b0, "reply_er_long");
    endtask

    task automatic test_noecho();
        send_rx(1, 8'h67);
        checks++;
        if (g_txs(1) !== 1'b0) begin errors++; $display("FAIL noecho_g got %b need 0", g_txs(1)); end
        send_rx(1, 8'h0D);
        serve_reply(1, 1'b0, "reply_er_g");
        send_rx(1, 8'h0D);
        checks++;
        if (vv_b !== 1'b0) begin errors++; $display("FAIL empty_valid got %b need 0", vv_b); end
        serve_reply(1, 1'b0, "reply_er_empty");
        send_rx(1, 8'h61);
        send_rx(1, 8'h0A);
        checks++;
        if (g_txs(1) !== 1'b0 || dc_b !== 4'd1) begin
            errors++;
            $display("FAIL lf_ignored got tx=%b cnt=%0d need 0/1", g_txs(1), dc_b);
        end
        send_rx(1, 8'h0D);
        checks++;
        if (vv_b !== 1'b1 || val_b !== 8'h0A) begin
            errors++;
            $display("FAIL commit_0A got v=%b val=%h need 1/0a", vv_b, val_b);
        end
        serve_reply(1, 1'b1, "reply_ok_a");
    endtask

    task automatic test_wide();
        string s = "DEADbeef";
        for (int i = 0; i < 8; i++) begin
            send_rx(2, s[i]);
            serve_tx(2, s[i], "echo_wide", 0);
        end
        checks++;
        if (dc_c !== 4'd8) begin errors++; $display("FAIL wide_cnt got %0d need 8", dc_c); end
        send_rx(2, 8'h0D);
        checks++;
        if (vv_c !== 1'b1 || val_c !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL commit_wide got v=%b val=%h need 1/deadbeef", vv_c, val_c);
        end
        serve_tx(2, 8'h0D, "echo_cr_wide", 0);
        serve_reply(2, 1'b1, "reply_ok_wide");
        tick();
        checks++;
        if (txcnt_c !== 13) begin errors++; $display("FAIL wide_tx_count got %0d need 13", txcnt_c); end
    endtask

    task automatic test_overrun();
        checks++;
        if (ov_b !== 1'b0) begin errors++; $display("FAIL overrun_pre got %b need 0", ov_b); end
        send_rx(1, 8'h31);
        send_rx(1, 8'h0D);
        serve_tx(1, 8'h4F, "ovr_O", 1);
        checks++;
        if (ov_b !== 1'b1) begin errors++; $display("FAIL overrun_set got %b need 1", ov_b); end
        serve_tx(1, 8'h6B, "ovr_k", 0);
        serve_tx(1, 8'h0D, "ovr_cr", 0);
        serve_tx(1, 8'h0A, "ovr_lf", 0);
        checks++;
        if (dc_b !== 4'd0 || val_b !== 8'h01) begin
            errors++;
            $display("FAIL ovr_dropped got cnt=%0d val=%h need 0/01", dc_b, val_b);
        end
        send_rx(1, 8'h37);
        send_rx(1, 8'h0D);
        checks++;
        if (vv_b !== 1'b1 || val_b !== 8'h07 || ov_b !== 1'b1) begin
            errors++;
            $display("FAIL ovr_acc got v=%b val=%h ov=%b need 1/07/1", vv_b, val_b, ov_b);
        end
        serve_reply(1, 1'b1, "reply_ok_7");
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        send_rx(0, 8'h31);
        serve_tx(0, 8'h31, "rm_echo_1", 0);
        send_rx(0, 8'h0D);
        serve_tx(0, 8'h0D, "rm_echo_cr", 0);
        serve_tx(0, 8'h4F, "rm_O", 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (g_txs(0) !== 1'b0 || g_txb(0) !== 8'h00 || val_a !== 8'h00 ||
            vv_a !== 1'b0 || dc_a !== 4'd0 || ov_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got tx=%b byte=%h val=%h v=%b cnt=%0d ov=%b need all 0",
                     g_txs(0), g_txb(0), val_a, vv_a, dc_a, ov_a);
        end
        txd[0] = 1'b1;
        tick();
        txd[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (g_txs(0)) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_mid_quiet got %0d pulses need 0", seen); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_echo_commit();
        test_too_long();
        test_noecho();
        test_wide();
        test_overrun();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
